// File: rtl/mem_mmio_unit_if.sv
// CPU, display and keyboard signals of mem_mmio_unit bundled as one interface.
// The slave modport is the memory side; the master modport is the CPU/system side.
interface mem_mmio_unit_if;
    logic [31:0] address;
    logic        isWrite;
    logic        isRead;
    logic [1:0]  accessSize;
    logic        signExtend;
    logic [31:0] writeData;
    logic [31:0] RD;
    logic        rdValid;
    logic        accessErr;
    logic [31:0] displayAddr;
    logic [31:0] displayData;
    logic [7:0]  key_reg;
    logic        sample;

    modport slave (
        input  address, isWrite, isRead, accessSize, signExtend, writeData,
        input  displayAddr, key_reg, sample,
        output RD, rdValid, accessErr, displayData
    );

    modport master (
        output address, isWrite, isRead, accessSize, signExtend, writeData,
        output displayAddr, key_reg, sample,
        input  RD, rdValid, accessErr, displayData
    );
endinterface

// File: rtl/mem_mmio_unit.sv
// Word RAM with a byte/halfword/word CPU port, a registered display read port,
// and a memory-mapped keyboard FIFO with a sticky overflow flag.
module mem_mmio_unit #(
    parameter int          DEPTH_WORDS = 4096,
    parameter int          KEY_DEPTH   = 8,
    parameter logic [31:0] KEY_ADDR    = 32'hFFFF_0000,
    parameter logic [31:0] STAT_ADDR   = 32'hFFFF_0004
) (
    input  logic            clock,
    input  logic            reset,
    mem_mmio_unit_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int KW = $clog2(KEY_DEPTH);
    localparam int CW = KW + 1;

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [7:0]    fifo_q [KEY_DEPTH];

    logic [KW-1:0] wr_ptr_q, wr_ptr_d;
    logic [KW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          sample_q;
    logic [31:0]   rd_q, rd_d;
    logic          rd_valid_q;
    logic          err_q;
    logic [31:0]   disp_q;

    logic [AW-1:0] word_idx;
    logic [AW-1:0] disp_idx;
    logic          misalign;
    logic          err;
    logic          key_hit, stat_hit, mmio_hit;
    logic          rd_ok, wr_ok, ram_we;
    logic          fifo_empty, fifo_full;
    logic          push, push_ok, pop, ovf_clr;
    logic [3:0]    be;
    logic [31:0]   wdat;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic          unused_disp_hi;

    assign word_idx       = bus.address[AW+1:2];
    assign disp_idx       = bus.displayAddr[AW-1:0];
    assign unused_disp_hi = ^bus.displayAddr[31:AW];

    always_comb begin
        misalign = 1'b0;
        case (bus.accessSize)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = bus.address[0];
            2'b10:   misalign = (bus.address[1:0] != 2'b00);
            default: misalign = 1'b1;
        endcase
    end

    assign err        = (bus.isRead | bus.isWrite) & misalign;
    assign key_hit    = (bus.address == KEY_ADDR);
    assign stat_hit   = (bus.address == STAT_ADDR);
    assign mmio_hit   = key_hit | stat_hit;
    assign rd_ok      = bus.isRead & ~err;
    assign wr_ok      = bus.isWrite & ~err;
    assign ram_we     = wr_ok & ~mmio_hit;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(KEY_DEPTH));
    assign push       = bus.sample & ~sample_q;
    assign pop        = rd_ok & key_hit & ~fifo_empty;
    // A pop in the same cycle frees a slot, so a push onto a full FIFO still lands.
    assign push_ok    = push & (~fifo_full | pop);
    assign ovf_clr    = wr_ok & stat_hit & bus.writeData[0];

    always_comb begin
        be   = 4'b1111;
        wdat = bus.writeData;
        case (bus.accessSize)
            2'b00: begin
                be   = 4'b0001 << bus.address[1:0];
                wdat = {4{bus.writeData[7:0]}};
            end
            2'b01: begin
                be   = bus.address[1] ? 4'b1100 : 4'b0011;
                wdat = {2{bus.writeData[15:0]}};
            end
            default: begin
                be   = 4'b1111;
                wdat = bus.writeData;
            end
        endcase
    end

    assign rd_word = mem_q[word_idx];
    assign rd_byte = rd_word[{bus.address[1:0], 3'b000} +: 8];
    assign rd_half = rd_word[{bus.address[1], 4'b0000} +: 16];

    always_comb begin
        rd_d = rd_q;
        if (rd_ok) begin
            if (key_hit) begin
                rd_d = fifo_empty ? 32'h0 : {24'h0, fifo_q[rd_ptr_q]};
            end else if (stat_hit) begin
                rd_d = {16'h0, ovf_q, 7'h0, 8'(count_q)};
            end else begin
                case (bus.accessSize)
                    2'b00:   rd_d = {{24{bus.signExtend & rd_byte[7]}}, rd_byte};
                    2'b01:   rd_d = {{16{bus.signExtend & rd_half[15]}}, rd_half};
                    default: rd_d = rd_word;
                endcase
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + KW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + KW'(1);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (ovf_clr)          ovf_d = 1'b0;
        if (push & ~push_ok)  ovf_d = 1'b1;
    end

    // Storage arrays are not reset; reset only blocks commits on its edge.
    always_ff @(posedge clock) begin
        if (!reset && ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[word_idx][8*i +: 8] <= wdat[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push_ok) fifo_q[wr_ptr_q] <= bus.key_reg;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            disp_q     <= '0;
            sample_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            rd_q       <= rd_d;
            rd_valid_q <= rd_ok;
            err_q      <= err;
            disp_q     <= mem_q[disp_idx];
            sample_q   <= bus.sample;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.RD          = rd_q;
    assign bus.rdValid     = rd_valid_q;
    assign bus.accessErr   = err_q;
    assign bus.displayData = disp_q;
endmodule

// File: doc/mem_mmio_unit.md
MEM_MMIO_UNIT -- requirements
Module: mem_mmio_unit

Interface
REQ-001 Parameter: DEPTH_WORDS, 4096, number of 32-bit data words; power of two, minimum 4.
REQ-002 Parameter: KEY_DEPTH, 8, key FIFO entries; power of two, minimum 2.
REQ-003 Parameter: KEY_ADDR, 32'hFFFF_0000, byte address of the key data register.
REQ-004 Parameter: STAT_ADDR, 32'hFFFF_0004, byte address of the key status register.
REQ-005 Port: clock, input, 1, single clock; all state updates on its rising edge.
REQ-006 Port: reset, input, 1, asynchronous, active-high.
REQ-007 Port: address, input, 32, byte address for the CPU port.
REQ-008 Port: isWrite, input, 1, CPU write strobe.
REQ-009 Port: isRead, input, 1, CPU read strobe.
REQ-010 Port: accessSize, input, 2: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-011 Port: signExtend, input, 1, sign-extend byte/halfword reads when high, zero-extend when low.
REQ-012 Port: writeData, input, 32, write data, right-aligned.
REQ-013 Port: RD, output, 32, registered CPU read data.
REQ-014 Port: rdValid, output, 1, RD holds new data this cycle.
REQ-015 Port: accessErr, output, 1, one-cycle pulse on a misaligned or reserved-size access.
REQ-016 Port: displayAddr, input, 32, word index for the display read port.
REQ-017 Port: displayData, output, 32, registered display read data.
REQ-018 Port: key_reg, input, 8, keyboard scan code.
REQ-019 Port: sample, input, 1, keyboard strobe, synchronous to clock.

Function
REQ-020 Word index = address[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored except for MMIO decode.
REQ-021 MMIO hit: address equals KEY_ADDR or STAT_ADDR, compared on all 32 bits; MMIO takes priority over RAM.
REQ-022 Alignment: halfword requires address[0]=0; word requires address[1:0]=0; accessSize=11 is always an error.
REQ-023 On error: no RAM write, no FIFO pop, accessErr=1 next cycle, rdValid=0, RD holds its previous value.
REQ-024 Writes: byte writes lane address[1:0] with writeData[7:0]; halfword writes lanes {address[1],0} and {address[1],1} with writeData[15:0]; word writes all lanes; other lanes are unchanged.
REQ-025 Writes to KEY_ADDR and STAT_ADDR: bit 0 of a write to STAT_ADDR clears the overflow flag; a write to KEY_ADDR is ignored; neither raises an error if aligned.
REQ-026 Reads: 1-cycle latency; RD and rdValid=1 appear on the cycle after isRead is sampled; rdValid=0 otherwise.
REQ-027 Byte/halfword read selects the lane by address[1:0] and extends per signExtend.
REQ-028 isRead and isWrite both high: the read returns the pre-write RAM contents (read-before-write); both operations occur.
REQ-029 Display port: displayData = word[displayAddr mod DEPTH_WORDS], registered every cycle and unaffected by isRead; if written in the same cycle, displayData returns old data.
REQ-030 Key capture: a 0->1 edge of sample, detected against a registered copy of sample, pushes key_reg into the FIFO; a held-high sample pushes only once.
REQ-031 FIFO full on push: the key is dropped and the sticky overflow flag is set.
REQ-032 Read of KEY_ADDR: RD = {24'b0, head}, or 0 if empty; pops one entry if non-empty; the access size is ignored if aligned.
REQ-033 Simultaneous push and pop: both occur and count is unchanged; on a full FIFO with a simultaneous pop, the push succeeds and overflow is not set.
REQ-034 Read of STAT_ADDR: RD = {16'b0, overflow, 7'b0, count[7:0]}; count ranges 0..KEY_DEPTH.
REQ-035 FIFO pointers wrap modulo KEY_DEPTH.

Reset
REQ-036 While reset=1: RD=0, rdValid=0, accessErr=0, displayData=0, FIFO empty (count=0, pointers=0), overflow=0, and the sample edge register is 0.
REQ-037 RAM contents are not reset; a read of a never-written word returns undefined data.
REQ-038 Reset asserted mid-access aborts the access; no write, pop or push is committed on the edge where reset=1.

Verification
REQ-039 Word write 0x12345678 @0x40, then a byte read @0x43 with signExtend=1 -> RD=0x00000012 one cycle later, rdValid=1.
REQ-040 Byte write 0x80 @0x41, then a halfword read @0x40 with signExtend=1 -> RD=0xFFFF8078.
REQ-041 Halfword write @0x41 -> accessErr pulse, no RAM change; a word read @0x40 returns the prior value.
REQ-042 Push 9 keys (0x01..0x09) with KEY_DEPTH=8 -> STAT reads 0x00008008; 8 KEY reads return 0x01..0x08; STAT then reads 0x00008000; a STAT write of 1 clears it to 0.
REQ-043 sample held high for 5 cycles with key_reg=100 -> exactly one push; a KEY read returns 100.
REQ-044 Reset asserted while a pop is issued, FIFO holding 3 keys -> count=0, RD=0 after reset; a KEY read returns 0.
